// File: rtl/ram_data_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_data_pkg
//  Description : Shared definitions for the multi-port data RAM: default
//                geometry, access opcode type, index-width helper and
//                slice-offset helper for the flattened per-port buses.
//  Revision    : 1.0  initial multi-port release
// ============================================================================
package ram_data_pkg;

    localparam int DW_DEF      = 16;
    localparam int AW_DEF      = 16;
    localparam int N_PORTS_DEF = 4;

    // Operation carried by a port's WR bit.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // Bits needed to index n items; a single item still gets a 1-bit index
    // so that index ports never collapse to zero width.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Low bit of slice p in a bus built from equal slices of width w.
    function automatic int slice_lo(input int p, input int w);
        return p * w;
    endfunction

endpackage : ram_data_pkg
`default_nettype wire

// File: rtl/ram_data_mp_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter over N requesters. The search starts at
//                the internal pointer and wraps upward; the first eligible
//                requester wins. The pointer moves just past the winner when
//                the caller consumes the grant.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                i_eligible[N]   - requesters competing this cycle
//                i_advance       - grant consumed, move the pointer
//                o_grant[N]      - one-hot grant (all zero when none)
//                o_grant_idx     - index of the granted requester
//                o_valid         - a requester is granted this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import ram_data_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             i_eligible,
    input  logic                     i_advance,
    output logic [N-1:0]             o_grant,
    output logic [clog2_min1(N)-1:0] o_grant_idx,
    output logic                     o_valid
);

    localparam int IW = clog2_min1(N);

    logic [IW-1:0] r_ptr;
    logic [N-1:0]  w_grant;
    logic [IW-1:0] w_idx;
    logic          w_valid;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;

    // Walk candidates ptr, ptr+1, ... modulo N. The sum is one bit wider
    // than the pointer so the wrap test works for any N, not only powers
    // of two.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_valid = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_cand = w_sum[IW-1:0];
            if (!w_valid && i_eligible[w_cand]) begin
                w_valid         = 1'b1;
                w_idx           = w_cand;
                w_grant[w_cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_valid) begin
            r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + IW'(1);
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_idx;
    assign o_valid     = w_valid;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/ram_data_mp.sv
`default_nettype none
// ============================================================================
//  Module      : ram_data_mp
//  Description : Multi-port synchronous data RAM shared by N cores. One
//                access per clock is granted round-robin; the granted port
//                sees a one-cycle ACK pulse, and read data is registered and
//                held per port until that port's next read completes.
//  Ports       : clk      - system clock
//                rst      - asynchronous active-high reset
//                REQ[N]   - per-port request, held until ACK
//                WR[N]    - per-port op: 1 write, 0 read
//                ADDBUS   - per-port address, slice p = [p*AW +: AW]
//                DATAIN   - per-port write data, slice p = [p*DW +: DW]
//                DATAOUT  - per-port registered read data
//                ACK[N]   - one-cycle completion pulse per port
//                GNT_ID   - index of the last granted port
//  Revision    : 1.0  initial multi-port release
// ============================================================================
module ram_data_mp
    import ram_data_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PORTS-1:0]             REQ,
    input  logic [N_PORTS-1:0]             WR,
    input  logic [N_PORTS*AW-1:0]          ADDBUS,
    input  logic [N_PORTS*DW-1:0]          DATAIN,
    output logic [N_PORTS*DW-1:0]          DATAOUT,
    output logic [N_PORTS-1:0]             ACK,
    output logic [clog2_min1(N_PORTS)-1:0] GNT_ID
);

    localparam int IW    = clog2_min1(N_PORTS);
    localparam int DEPTH = 2 ** AW;

    // ------------------------------------------------------------------
    // Storage and output registers
    // ------------------------------------------------------------------
    logic [DW-1:0]         r_mem [DEPTH];
    logic [N_PORTS*DW-1:0] r_dout;
    logic [N_PORTS-1:0]    r_ack;
    logic [IW-1:0]         r_gnt_id;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [N_PORTS-1:0] w_eligible;
    logic [N_PORTS-1:0] w_gnt_onehot;
    logic [IW-1:0]      w_gnt_idx;
    logic               w_gnt_valid;

    // A port in its ACK cycle is masked out, so a REQ still held high
    // while the requester reacts to ACK is never served a second time.
    assign w_eligible = REQ & ~r_ack;

    rr_arbiter #(
        .N (N_PORTS)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_eligible  (w_eligible),
        .i_advance   (w_gnt_valid),
        .o_grant     (w_gnt_onehot),
        .o_grant_idx (w_gnt_idx),
        .o_valid     (w_gnt_valid)
    );

    // ------------------------------------------------------------------
    // Granted port's request fields
    // ------------------------------------------------------------------
    op_e           w_gnt_op;
    logic [AW-1:0] w_gnt_addr;
    logic [DW-1:0] w_gnt_din;
    logic          w_mem_we;

    assign w_gnt_op   = op_e'(WR[w_gnt_idx]);
    assign w_gnt_addr = ADDBUS[slice_lo(int'(w_gnt_idx), AW) +: AW];
    assign w_gnt_din  = DATAIN[slice_lo(int'(w_gnt_idx), DW) +: DW];

    // The array has no reset, so the write enable is gated with rst to
    // drop any access that is in flight while reset is held.
    assign w_mem_we = w_gnt_valid && (w_gnt_op == OP_WRITE) && !rst;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_gnt_addr] <= w_gnt_din;
        end
    end

    // ------------------------------------------------------------------
    // Completion, read data and debug index
    // ------------------------------------------------------------------
    // Only one access happens per edge, so a read always sees the array
    // contents from before this edge with no write/read hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack    <= '0;
            r_dout   <= '0;
            r_gnt_id <= '0;
        end else begin
            // One-hot grant is all zero when nobody is granted, which
            // clears every ACK bit on idle cycles.
            r_ack <= w_gnt_onehot;
            if (w_gnt_valid) begin
                r_gnt_id <= w_gnt_idx;
                if (w_gnt_op == OP_READ) begin
                    r_dout[slice_lo(int'(w_gnt_idx), DW) +: DW] <= r_mem[w_gnt_addr];
                end
            end
        end
    end

    assign DATAOUT = r_dout;
    assign ACK     = r_ack;
    assign GNT_ID  = r_gnt_id;

endmodule : ram_data_mp
`default_nettype wire
